// File: rtl/sevenseg_scan_if.sv
// rtl/sevenseg_scan_if.sv - digit bus and 7-segment display signals for sevenseg_scan
interface sevenseg_scan_if;
  logic [2:0] m10;
  logic [3:0] m1;
  logic [2:0] s10;
  logic [3:0] s1;
  logic       pause;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  modport master (output m10, m1, s10, s1, pause, input seg, an, dp);
  modport slave  (input m10, m1, s10, s1, pause, output seg, an, dp);
endinterface

// File: rtl/sevenseg_scan.sv
// rtl/sevenseg_scan.sv - 4-digit multiplexed common-anode 7-segment driver with per-frame snapshot
// Optional blink-while-paused enabled by defining SEVENSEG_SCAN_BLINK_EN.
module sevenseg_scan #(
  parameter logic [15:0] SCAN_DIV  = 16'd50000,
  parameter logic [25:0] BLINK_DIV = 26'd25000000
) (
  input  logic            clkDis,
  input  logic            rstN,
  sevenseg_scan_if.slave  bus
);

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [13:0] snap_q, snap_d;
  logic        load_first_q, load_first_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  logic [13:0] live;
  logic [13:0] snap_src;
  logic [3:0]  digit;
  logic        cnt_wrap;
  logic        blank;

  // Snapshot layout: {m10, m1, s10, s1}
  assign live = {bus.m10, bus.m1, bus.s10, bus.s1};

`ifdef SEVENSEG_SCAN_BLINK_EN
  logic [25:0] blink_cnt_q, blink_cnt_d;
  logic        phase_q, phase_d;

  // Blink timing restarts from phase 0 whenever pause drops.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (!bus.pause) begin
      blink_cnt_d = 26'd0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_DIV - 26'd1) begin
      blink_cnt_d = 26'd0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 26'd1;
    end
  end

  always_ff @(posedge clkDis or negedge rstN) begin
    if (!rstN) begin
      blink_cnt_q <= 26'd0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign blank = bus.pause && phase_q;
`else
  logic unused_blink;
  assign unused_blink = ^{bus.pause, BLINK_DIV};
  assign blank        = 1'b0;
`endif

  always_comb begin
    cnt_wrap     = (cnt_q == SCAN_DIV - 16'd1);
    cnt_d        = cnt_wrap ? 16'd0 : cnt_q + 16'd1;
    idx_d        = cnt_wrap ? idx_q + 2'd1 : idx_q;
    load_first_d = 1'b0;
    // The first edge after reset shows live inputs so the display is never stale.
    snap_src     = load_first_q ? live : snap_q;
    snap_d       = snap_q;
    if (load_first_q || (cnt_wrap && idx_q == 2'd3))
      snap_d = live;

    case (idx_q)
      2'd0:    digit = snap_src[3:0];
      2'd1:    digit = {1'b0, snap_src[6:4]};
      2'd2:    digit = snap_src[10:7];
      default: digit = {1'b0, snap_src[13:11]};
    endcase

    an_d  = ~(4'b0001 << idx_q);
    seg_d = decode(digit);
    dp_d  = (idx_q != 2'd2);
    if (blank) begin
      an_d = 4'b1111;
      dp_d = 1'b1;
    end
  end

  always_ff @(posedge clkDis or negedge rstN) begin
    if (!rstN) begin
      cnt_q        <= 16'd0;
      idx_q        <= 2'd0;
      snap_q       <= 14'd0;
      load_first_q <= 1'b1;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      load_first_q <= load_first_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb/tb_sevenseg_scan.sv - directed self-checking bench for sevenseg_scan (SCAN_DIV=4, BLINK_DIV=8)
module tb_sevenseg_scan;

`ifdef SEVENSEG_SCAN_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  logic [6:0] tab [16];

  sevenseg_scan_if intf ();

  sevenseg_scan #(.SCAN_DIV(16'd4), .BLINK_DIV(26'd8)) dut (
    .clkDis (clk),
    .rstN   (rst_n),
    .bus    (intf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] an, input logic [6:0] seg, input logic dp);
    check({tag, ".an"},  {28'd0, intf.an},  {28'd0, an});
    check({tag, ".seg"}, {25'd0, intf.seg}, {25'd0, seg});
    check({tag, ".dp"},  {31'd0, intf.dp},  {31'd0, dp});
  endtask

  initial begin
    logic [3:0]  exp_an [4];
    logic [6:0]  exp_seg [4];
    logic        exp_blank;
    tests = 0;
    fails = 0;
    tab[0]  = 7'b1000000; tab[1]  = 7'b1111001; tab[2]  = 7'b0100100; tab[3]  = 7'b0110000;
    tab[4]  = 7'b0011001; tab[5]  = 7'b0010010; tab[6]  = 7'b0000010; tab[7]  = 7'b1111000;
    tab[8]  = 7'b0000000; tab[9]  = 7'b0010000;
    for (int i = 10; i < 16; i++) tab[i] = 7'b0111111;
    exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b0111;
    exp_seg[0] = 7'b0100100; exp_seg[1] = 7'b0011001; exp_seg[2] = 7'b0010000; exp_seg[3] = 7'b0010010;

    rst_n = 1'b0;
    intf.m10 = 3'd5; intf.m1 = 4'd9; intf.s10 = 3'd4; intf.s1 = 4'd7; intf.pause = 1'b0;

    // Reset hold, then first edge bypasses the snapshot
    tick(5);
    check_out("reset", 4'b1111, 7'b1111111, 1'b1);
    rst_n = 1'b1;
    tick(1);
    check_out("first_edge", 4'b1110, 7'b1111000, 1'b1);

    // s1 changes mid-frame; frame 1 keeps the edge-1 snapshot
    intf.s1 = 4'd2;
    tick(3);  check_out("f1_idx0_end", 4'b1110, 7'b1111000, 1'b1);
    tick(1);  check_out("f1_idx1", 4'b1101, 7'b0011001, 1'b1);
    tick(3);  check_out("f1_idx1_end", 4'b1101, 7'b0011001, 1'b1);
    tick(1);  check_out("f1_idx2", 4'b1011, 7'b0010000, 1'b0);
    tick(3);  check_out("f1_idx2_end", 4'b1011, 7'b0010000, 1'b0);
    tick(1);  check_out("f1_idx3", 4'b0111, 7'b0010010, 1'b1);
    tick(4);

    // Full frame with 5,9,4,2: each digit held 4 cycles
    for (int i = 0; i < 16; i++) begin
      check_out($sformatf("scan_c%0d", i), exp_an[i/4], exp_seg[i/4], (i/4 == 2) ? 1'b0 : 1'b1);
      tick(1);
    end

    // Decode sweep, one value per frame on the rightmost digit
    for (int v = 0; v < 16; v++) begin
      intf.s1 = 4'(v);
      tick(16);
      check_out($sformatf("decode_%0d", v), 4'b1110, tab[v], 1'b1);
    end

    // Tearing: change s1 during idx1, visible only next frame
    intf.s1 = 4'd3;
    tick(16); check_out("tear_prev", 4'b1110, 7'b0110000, 1'b1);
    tick(4);  check_out("tear_idx1", 4'b1101, 7'b0011001, 1'b1);
    intf.s1 = 4'd8;
    tick(4);  check_out("tear_idx2", 4'b1011, 7'b0010000, 1'b0);
    tick(4);  check_out("tear_idx3", 4'b0111, 7'b0010010, 1'b1);
    tick(4);  check_out("tear_next", 4'b1110, 7'b0000000, 1'b1);

    // Mid-scan asynchronous reset during idx2
    tick(8);  check_out("pre_reset", 4'b1011, 7'b0010000, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_out("async_reset", 4'b1111, 7'b1111111, 1'b1);
    @(negedge clk);
    intf.s1 = 4'd6;
    rst_n = 1'b1;
    tick(1);  check_out("restart", 4'b1110, 7'b0000010, 1'b1);

    // Pause: blinks 8 blank / 8 scanning only in blink builds
    intf.pause = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      tick(1);
      exp_blank = BLINK_EN && (i >= 9) && (i <= 16);
      check($sformatf("blink_c%0d", i), {31'd0, intf.an == 4'b1111}, {31'd0, exp_blank});
    end
    tick(2);
    check("blink_c26", {31'd0, intf.an == 4'b1111}, {31'd0, BLINK_EN});
    check("blink_dp26", {31'd0, intf.dp}, {31'd0, BLINK_EN || (intf.an != 4'b1011)});
    intf.pause = 1'b0;
    tick(1);
    check("unpause", {31'd0, intf.an == 4'b1111}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan.md
Name: sevenseg_scan

Overview:
Display-side consumer of the stopwatch digit bus (m10/m1/s10/s1) and the debounced pause level. It time-multiplexes four digits onto one common-anode 7-segment bank and decodes BCD to segments. It snapshots the digits once per frame so the display never tears, and can optionally blink while paused.

Parameters:
SCAN_DIV, 16'd50000, clkDis cycles each digit stays lit (must be >= 2)
BLINK_DIV, 26'd25000000, clkDis cycles per blink half-period (BLINK_EN builds only)

Ports:
clkDis  in  1  display clock; all state on rising edge
rstN  in  1  reset, asynchronous assert, active-low
m10  in  3  minutes tens, 0-5
m1  in  4  minutes ones, 0-9
s10  in  3  seconds tens, 0-5
s1  in  4  seconds ones, 0-9
pause  in  1  debounced pause level (1 = paused)
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
an  out  4  anode enables, active-low; an[0] = rightmost digit
dp  out  1  decimal point, active-low

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (rstN=0) outputs, held: an=4'b1111, seg=7'b1111111, dp=1.
- Reset internal state: cnt=0, idx=0, snapshot=0, loadFirst=1, blink phase=0.
- Scan counter cnt:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - At cnt==SCAN_DIV-1, idx advances 0->1->2->3->0.
  - Digit map: idx0 = s1 on an[0]; idx1 = s10 on an[1]; idx2 = m1 on an[2]; idx3 = m10 on an[3].
- Snapshot of {m10,m1,s10,s1}:
  - Captured on the first clkDis edge after reset release (loadFirst is then cleared).
  - Thereafter captured only on the edge where cnt==SCAN_DIV-1 && idx==3, i.e. on the frame wrap.
  - Input changes mid-frame stay invisible until the next frame.
- Outputs are registered: an/seg/dp reflect idx and the snapshot one cycle after idx changes.
  - Exactly one an bit is low at any time after the first post-reset edge.
  - No cycle has two anodes active.
- First post-reset edge drives an=4'b1110 and seg=decode(s1 input on that same edge), so the snapshot bypass applies on that edge.
- Decode table (seg, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any value 10-15 shows a dash, 0111111.
  - 3-bit digits are zero-extended before decode.
- dp: 0 while idx==2 (separator between minutes and seconds), else 1.
- Reset mid-scan: asynchronously forces the reset values immediately. After release, scanning restarts at idx0 with a fresh snapshot.
- Idx and frame timing are independent of input values.
- Without BLINK_EN, pause has no effect.

Optional Feature:
- Macro: SEVENSEG_SCAN_BLINK_EN.
- Defined:
  - A blink counter counts 0..BLINK_DIV-1; blink phase toggles at each wrap and resets to 0.
  - While pause==1 and phase==1: an=4'b1111 and dp=1, with registered one-cycle latency. The scan counter and idx keep running.
  - When pause falls, phase is cleared on the next edge and the display reappears within one cycle.
- Undefined: no blink counter exists; pause is unused; behaviour is exactly as above.

Test Plan:
1. Reset and first edge: hold rstN=0 for 5 cycles -> an=1111, seg=1111111, dp=1. Release with s1=7 -> next edge an=1110, seg=1111000.
2. Scan order, SCAN_DIV=4, inputs m10=5 m1=9 s10=4 s1=2:
   - an sequence 1110,1101,1011,0111, each held 4 cycles.
   - seg sequence 0100100, 0011001, 0010000, 0010010.
   - dp=0 only while an=1011.
3. Decode sweep: s1 = 0..15 across successive frames -> the table codes for 0-9; 10-15 show 0111111.
4. Tearing: change s1 from 3 to 8 while idx==1 -> the remainder of the frame is unaffected. Next frame an=1110 shows 0000000; the prior an=1110 window showed 0110000.
5. Mid-scan reset: assert rstN=0 during idx2 -> same-cycle an=1111, seg=1111111. After release -> restarts at an=1110.
6. (BLINK_EN, BLINK_DIV=8) pause=1:
   - an alternates 8 cycles blank (1111) / 8 cycles scanning.
   - pause=0 -> scanning resumes within 1 cycle.
